bsg_wormhole_link_concentrator_rr: RTL and testbench

- Merges num_in_p ready-and wormhole links onto one output link, such as the processor's DRAM command port plus bypass traffic heading to a single router port.
- Generalises the fixed 3-into-1 link aggregation at the chip toplevel: channel count, flit width, length-field position and per-input buffer depth are all parameters.
- Arbitration mode is selectable: round-robin or fixed priority.
- A grant is held for a whole wormhole packet. The header's length field determines how many body flits follow.

---
 rtl/bsg_wormhole_link_concentrator_rr.sv | 134 +++++++++++++
 tb/tb_bsg_wormhole_link_concentrator_rr.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_link_concentrator_rr.sv
// Wormhole link concentrator: merges num_in_p ready/valid links onto one output,
// holding each grant for a whole packet (round-robin or fixed-priority selection).
module bsg_wormhole_link_concentrator_rr #(
  parameter int num_in_p        = 4,
  parameter int flit_width_p    = 32,
  parameter int len_width_p     = 4,
  parameter int len_offset_p    = 8,
  parameter int fifo_els_p      = 2,
  parameter int priority_mode_p = 0,
  parameter int count_width_p   = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_in_p*flit_width_p-1:0]  data_i,
  input  logic [num_in_p-1:0]               v_i,
  output logic [num_in_p-1:0]               ready_o,
  output logic [flit_width_p-1:0]           data_o,
  output logic                              v_o,
  input  logic                              ready_i,
  output logic [$clog2(num_in_p)-1:0]       grant_o,
  output logic                              busy_o,
  output logic [count_width_p-1:0]          pkt_count_o
);
  localparam int sel_w = $clog2(num_in_p);
  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int cnt_w = ptr_w + 1;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t                  state;
  logic [sel_w-1:0]        grant_r, last_r, winner, idx;
  logic [len_width_p-1:0]  cnt_r, len;
  logic                    accept_en, any_valid, xfer;
  logic [flit_width_p-1:0] mem [num_in_p][fifo_els_p];
  logic [ptr_w-1:0]        rd_ptr [num_in_p];
  logic [ptr_w-1:0]        wr_ptr [num_in_p];
  logic [cnt_w-1:0]        used [num_in_p];
  logic [num_in_p-1:0]     empty, full, enq, deq;

  // accept_en keeps ready_o low until the first clock after reset releases
  always_comb begin
    for (int k = 0; k < num_in_p; k++) begin
      empty[k] = (used[k] == '0);
      full[k]  = (used[k] == cnt_w'(fifo_els_p));
      enq[k]   = v_i[k] & ready_o[k];
      deq[k]   = xfer & (grant_r == sel_w'(k));
    end
  end

  assign ready_o = accept_en ? ~full : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_in_p; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        used[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < num_in_p; k++) begin
        if (enq[k]) wr_ptr[k] <= wr_ptr[k] + ptr_w'(1);
        if (deq[k]) rd_ptr[k] <= rd_ptr[k] + ptr_w'(1);
        used[k] <= used[k] + cnt_w'(enq[k]) - cnt_w'(deq[k]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < num_in_p; k++)
      if (enq[k]) mem[k][wr_ptr[k]] <= data_i[k*flit_width_p +: flit_width_p];
  end

  // Scan downward so the candidate nearest the search start is assigned last
  always_comb begin
    winner = '0;
    idx    = '0;
    if (priority_mode_p == 1) begin
      for (int i = num_in_p - 1; i >= 0; i--)
        if (!empty[i]) winner = sel_w'(i);
    end else begin
      for (int i = num_in_p; i >= 1; i--) begin
        idx = sel_w'((int'(last_r) + i) % num_in_p);
        if (!empty[idx]) winner = idx;
      end
    end
  end

  assign any_valid   = |(~empty);
  assign data_o      = mem[grant_r][rd_ptr[grant_r]];
  assign v_o         = (state == HDR) | ((state == BODY) & ~empty[grant_r]);
  assign xfer        = v_o & ready_i;
  assign len         = data_o[len_offset_p +: len_width_p];
  assign busy_o      = (state != IDLE);
  assign grant_o     = grant_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      grant_r     <= '0;
      last_r      <= sel_w'(num_in_p - 1);
      cnt_r       <= '0;
      pkt_count_o <= '0;
      accept_en   <= 1'b0;
    end else begin
      accept_en <= 1'b1;
      case (state)
        IDLE: if (any_valid) begin
          grant_r <= winner;
          state   <= HDR;
        end
        HDR: if (xfer) begin
          if (len == '0) begin
            state       <= IDLE;
            last_r      <= grant_r;
            pkt_count_o <= pkt_count_o + count_width_p'(1);
          end else begin
            cnt_r <= len;
            state <= BODY;
          end
        end
        BODY: if (xfer) begin
          cnt_r <= cnt_r - len_width_p'(1);
          if (cnt_r == len_width_p'(1)) begin
            state       <= IDLE;
            last_r      <= grant_r;
            pkt_count_o <= pkt_count_o + count_width_p'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_link_concentrator_rr.sv
// Scoreboard bench for the wormhole concentrator: per-input feeder queues,
// expected-flit queues popped by an output monitor, plus directed timing checks.
module tb_bsg_wormhole_link_concentrator_rr;
  logic        clk = 0;
  logic        rst = 1;
  logic [127:0] data_i = '0;
  logic [3:0]  v_i = '0;
  logic [3:0]  ready_o;
  logic [31:0] data_o;
  logic        v_o;
  logic        ready_i = 1;
  logic [1:0]  grant_o;
  logic        busy_o;
  logic [15:0] pkt_count_o;

  // second instance: fixed priority, 2-bit counter, sees inputs only when b_en=1
  logic        b_en = 0;
  logic [3:0]  v_b_in, ready_b;
  logic [31:0] data_b;
  logic        v_b, busy_b;
  logic [1:0]  grant_b, cnt_b;
  assign v_b_in = v_i & {4{b_en}};

  int errors = 0;
  int checks = 0;
  logic [31:0] in_q [4][$];
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [3:0]  take;

  always #5 clk = ~clk;

  bsg_wormhole_link_concentrator_rr dut (
    .clk_i(clk), .reset_i(rst), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .grant_o(grant_o),
    .busy_o(busy_o), .pkt_count_o(pkt_count_o));

  bsg_wormhole_link_concentrator_rr #(.priority_mode_p(1), .count_width_p(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .data_i(data_i), .v_i(v_b_in), .ready_o(ready_b),
    .data_o(data_b), .v_o(v_b), .ready_i(1'b1), .grant_o(grant_b),
    .busy_o(busy_b), .pkt_count_o(cnt_b));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] flit(int k, int tag, int j, int len);
    if (j == 0) return {8'(k), 8'(tag), 4'h0, 4'(len), 8'hA5};
    return {8'(k), 8'(tag + j), 4'h0, 4'((tag + j) & 15), 8'hA5};
  endfunction

  task automatic send(int k, int len, int tag);
    for (int j = 0; j <= len; j++) in_q[k].push_back(flit(k, tag, j, len));
  endtask
  task automatic expect_a(int k, int len, int tag);
    for (int j = 0; j <= len; j++) qa.push_back(flit(k, tag, j, len));
  endtask
  task automatic expect_b(int k, int len, int tag);
    for (int j = 0; j <= len; j++) qb.push_back(flit(k, tag, j, len));
  endtask

  // feeder: present queue heads, pop what the DUT accepted at the edge
  always begin
    @(negedge clk);
    take = v_i & ready_o;
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (take[k] && in_q[k].size() > 0) void'(in_q[k].pop_front());
    #1;
    for (int k = 0; k < 4; k++) begin
      if (in_q[k].size() > 0) begin
        v_i[k] = 1'b1;
        data_i[k*32 +: 32] = in_q[k][0];
      end else begin
        v_i[k] = 1'b0;
      end
    end
  end

  // monitor: every output handshake must match the next expected flit
  always @(negedge clk) begin
    if (!rst) begin
      if (v_o && ready_i) begin
        if (qa.size() == 0) check("a_unexpected_flit", {32'h0, data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("a_flit", {32'h0, data_o}, {32'h0, qa.pop_front()});
      end
      if (v_b) begin
        if (qb.size() == 0) check("b_unexpected_flit", {32'h0, data_b}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("b_flit", {32'h0, data_b}, {32'h0, qb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_v(int bound);
    int n = 0;
    while (!v_o && n < bound) begin tick(); n++; end
    check("wait_v_timeout", 64'(n >= bound), 64'h0);
  endtask

  task automatic wait_done(int bound);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || busy_o || busy_b || in_q[0].size() > 0 ||
            in_q[1].size() > 0 || in_q[2].size() > 0 || in_q[3].size() > 0) && n < bound) begin
      tick(); n++;
    end
    check("wait_done_timeout", 64'(n >= bound), 64'h0);
  endtask

  task automatic assert_reset();
    rst = 1;
    for (int k = 0; k < 4; k++) in_q[k].delete();
    qa.delete();
    qb.delete();
    #1;
    check("rst_v_o", 64'(v_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_pkt_count", 64'(pkt_count_o), 64'h0);
    check("rst_ready", 64'(ready_o), 64'h0);
    tick();
    tick();
    rst = 0;
    check("ready_before_first_clk", 64'(ready_o), 64'h0);
    tick();
    check("ready_first_clk", 64'(ready_o), 64'hF);
  endtask

  logic [31:0] held;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_ready", 64'(ready_o), 64'h0);
    check("reset_v_o", 64'(v_o), 64'h0);
    check("reset_busy", 64'(busy_o), 64'h0);
    check("reset_grant", 64'(grant_o), 64'h0);
    check("reset_pkt_count", 64'(pkt_count_o), 64'h0);
    rst = 0;
    check("ready_before_first_clk", 64'(ready_o), 64'h0);
    tick();
    check("ready_first_clk", 64'(ready_o), 64'hF);

    // single input, len=3: header two cycles after acceptance, four back-to-back flits
    send(0, 3, 16);
    expect_a(0, 3, 16);
    tick();
    tick();
    check("lat_t_plus_1_v", 64'(v_o), 64'h0);
    tick();
    check("lat_t_plus_2_v", 64'(v_o), 64'h1);
    check("single_grant", 64'(grant_o), 64'h0);
    check("single_busy", 64'(busy_o), 64'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("single_stream_v", 64'(v_o), 64'h1);
    end
    tick();
    check("single_busy_fall", 64'(busy_o), 64'h0);
    check("single_pkt_count", 64'(pkt_count_o), 64'h1);

    // round-robin fairness: two rounds of len=0 packets on all inputs
    assert_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) send(k, 0, 32 + r * 8 + k);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) expect_a(k, 0, 32 + r * 8 + k);
    wait_v(20);
    for (int i = 0; i < 8; i++) begin
      check("rr_hdr_v", 64'(v_o), 64'h1);
      check("rr_grant", 64'(grant_o), 64'(i % 4));
      tick();
      check("rr_gap_v", 64'(v_o), 64'h0);
      tick();
    end
    wait_done(50);
    check("rr_pkt_count", 64'(pkt_count_o), 64'h8);

    // fixed priority vs round-robin after input 1 was served last
    b_en = 1;
    send(1, 1, 64);
    expect_a(1, 1, 64);
    expect_b(1, 1, 64);
    wait_done(50);
    send(1, 1, 72);
    send(2, 1, 80);
    expect_a(2, 1, 80);
    expect_a(1, 1, 72);
    expect_b(1, 1, 72);
    expect_b(2, 1, 80);
    wait_done(50);
    check("b_pkt_count", 64'(cnt_b), 64'h3);
    send(3, 0, 88);
    expect_a(3, 0, 88);
    expect_b(3, 0, 88);
    wait_done(50);
    check("b_count_wrap", 64'(cnt_b), 64'h0);
    b_en = 0;

    // backpressure mid-packet while input 1 fills
    send(0, 5, 96);
    expect_a(0, 5, 96);
    expect_a(1, 2, 112);
    wait_v(20);
    tick();
    tick();
    check("bp_v_before_stall", 64'(v_o), 64'h1);
    held = data_o;
    ready_i = 0;
    send(1, 2, 112);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_data_hold", 64'(data_o), 64'(held));
      check("bp_v_hold", 64'(v_o), 64'h1);
      check("bp_grant", 64'(grant_o), 64'h0);
    end
    check("bp_ready1_full", 64'(ready_o[1]), 64'h0);
    ready_i = 1;
    wait_done(60);

    // body starvation: late body flits, input 3 must wait
    in_q[0].push_back(flit(0, 128, 0, 2));
    expect_a(0, 2, 128);
    expect_a(3, 0, 144);
    wait_v(20);
    check("starve_hdr_grant", 64'(grant_o), 64'h0);
    tick();
    send(3, 0, 144);
    for (int i = 0; i < 5; i++) begin
      check("starve_v", 64'(v_o), 64'h0);
      check("starve_busy", 64'(busy_o), 64'h1);
      check("starve_grant", 64'(grant_o), 64'h0);
      tick();
    end
    in_q[0].push_back(flit(0, 128, 1, 2));
    in_q[0].push_back(flit(0, 128, 2, 2));
    wait_done(60);

    // async reset mid-BODY; afterwards the search must restart at input 0
    send(1, 0, 160);
    expect_a(1, 0, 160);
    wait_done(50);
    send(1, 3, 168);
    expect_a(1, 3, 168);
    wait_v(20);
    tick();
    tick();
    check("pre_rst_busy", 64'(busy_o), 64'h1);
    #1;
    assert_reset();
    send(2, 0, 176);
    send(0, 0, 184);
    expect_a(0, 0, 184);
    expect_a(2, 0, 176);
    wait_done(50);
    check("post_rst_pkt_count", 64'(pkt_count_o), 64'h2);

    // maximum length: len=15 gives a 16-flit packet
    send(3, 15, 200);
    expect_a(3, 15, 200);
    wait_done(100);
    check("max_len_pkt_count", 64'(pkt_count_o), 64'h3);
    check("max_len_busy", 64'(busy_o), 64'h0);
    check("final_queue_a", 64'(qa.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
